// File: rtl/icache_fill.sv
// Direct-mapped, read-only instruction cache with 2-word lines.
// Hits are combinational; a miss runs a two-beat fill from memory before the retry hits.
module icache_fill #(
  parameter int NSETS  = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [31:0]       imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [31:0]       iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 29 - IW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL0 = 2'd1;
  localparam logic [1:0] S_FILL1 = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [NSETS-1:0]  r_valid;
  logic [TW-1:0]     r_tag   [NSETS];
  logic [WORD_W-1:0] r_data0 [NSETS];
  logic [WORD_W-1:0] r_data1 [NSETS];
  logic [WORD_W-1:0] r_buf0;
  logic [28:0]       r_miss_addr;

  logic [TW-1:0]     w_tag;
  logic [IW-1:0]     w_idx;
  logic              w_woff;
  logic              w_hit;
  logic              w_miss;
  logic              w_beat0_done;
  logic              w_fill_done;
  logic [IW-1:0]     w_fill_idx;
  logic [TW-1:0]     w_fill_tag;
  logic              w_unused_bits;

  assign w_tag         = imemaddr[31:IW+3];
  assign w_idx         = imemaddr[IW+2:3];
  assign w_woff        = imemaddr[2];
  assign w_unused_bits = ^imemaddr[1:0];

  assign w_fill_idx = r_miss_addr[IW-1:0];
  assign w_fill_tag = r_miss_addr[28:IW];

  // Lookup is only meaningful in IDLE: no hit-under-miss.
  assign w_hit  = (r_state == S_IDLE) && imemREN && r_valid[w_idx]
                  && (r_tag[w_idx] == w_tag);
  assign w_miss = (r_state == S_IDLE) && imemREN && !w_hit;

  assign w_beat0_done = (r_state == S_FILL0) && !iwait;
  assign w_fill_done  = (r_state == S_FILL1) && !iwait;

  assign ihit = w_hit;

  always_comb begin
    imemload = '0;
    if (w_hit) begin
      imemload = w_woff ? r_data1[w_idx] : r_data0[w_idx];
    end
  end

  always_comb begin
    iREN  = 1'b0;
    iaddr = '0;
    case (r_state)
      S_FILL0: begin
        iREN  = 1'b1;
        iaddr = {r_miss_addr, 3'b000};
      end
      S_FILL1: begin
        iREN  = 1'b1;
        iaddr = {r_miss_addr, 3'b100};
      end
      default: begin
        iREN  = 1'b0;
        iaddr = '0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_miss)       w_state_nxt = S_FILL0;
      S_FILL0: if (w_beat0_done) w_state_nxt = S_FILL1;
      S_FILL1: if (w_fill_done)  w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: a reset mid-fill abandons the fill and leaves the set invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_buf0      <= '0;
      r_miss_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_miss) begin
        r_miss_addr <= imemaddr[31:3];
      end
      if (w_beat0_done) begin
        r_buf0 <= iload;
      end
      if (w_fill_done) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies them.
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]   <= w_fill_tag;
      r_data0[w_fill_idx] <= r_buf0;
      r_data1[w_fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_fill.sv
// Directed bench for icache_fill: reset, cold miss, wait states, conflict and mid-fill request changes.
module tb_icache_fill;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_checks = 0;
  int n_errors = 0;

  icache_fill #(.NSETS(16), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA_0001;
    if (a == 32'h44) return 32'hAAAA_0002;
    return 32'hC000_0000 | a;
  endfunction

  assign iload = mem_word(iaddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic [31:0] a, input logic w);
    imemREN  = ren;
    imemaddr = a;
    iwait    = w;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_fill(input string tag, input logic [31:0] a);
    check({tag, "_iren"}, {31'd0, iREN}, 32'd1);
    check({tag, "_iaddr"}, iaddr, a);
    check({tag, "_ihit"}, {31'd0, ihit}, 32'd0);
  endtask

  task automatic check_hit(input string tag, input logic [31:0] d);
    check({tag, "_ihit"}, {31'd0, ihit}, 32'd1);
    check({tag, "_load"}, imemload, d);
    check({tag, "_iren"}, {31'd0, iREN}, 32'd0);
  endtask

  initial begin
    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) next_cycle();
    nRST = 1'b1;
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_iren", {31'd0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_load", imemload, 32'd0);

    // Reset while FILL0 is stalled
    drive(1'b1, 32'h40, 1'b1);
    check("r0_miss", {31'd0, ihit}, 32'd0);
    next_cycle();
    drive(1'b1, 32'h40, 1'b1);
    check_fill("r1", 32'h40);
    #1 nRST = 1'b0;
    #1;
    check("ar_iren", {31'd0, iREN}, 32'd0);
    check("ar_iaddr", iaddr, 32'd0);
    check("ar_ihit", {31'd0, ihit}, 32'd0);
    check("ar_load", imemload, 32'd0);
    next_cycle();
    nRST = 1'b1;

    // Cold miss, zero-wait
    drive(1'b1, 32'h40, 1'b0);
    check("c0_miss", {31'd0, ihit}, 32'd0);
    check("c0_iren", {31'd0, iREN}, 32'd0);
    next_cycle();
    check_fill("c1", 32'h40);
    next_cycle();
    check_fill("c2", 32'h44);
    next_cycle();
    check_hit("c3", 32'hAAAA_0001);
    next_cycle();
    drive(1'b1, 32'h44, 1'b0);
    check_hit("c4", 32'hAAAA_0002);

    drive(1'b0, 32'h40, 1'b0);
    check("noren_ihit", {31'd0, ihit}, 32'd0);
    check("noren_load", imemload, 32'd0);

    // Conflict on index 8
    drive(1'b1, 32'hC0, 1'b0);
    check("k0_miss", {31'd0, ihit}, 32'd0);
    next_cycle();
    check_fill("k1", 32'hC0);
    next_cycle();
    check_fill("k2", 32'hC4);
    next_cycle();
    check_hit("k3", 32'hC000_00C0);

    // Refetch of 0x40 misses; fill with 3 wait cycles per beat
    drive(1'b1, 32'h40, 1'b1);
    check("w0_miss", {31'd0, ihit}, 32'd0);
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      drive(1'b1, 32'h40, (c == 4 || c == 8) ? 1'b0 : 1'b1);
      check_fill($sformatf("w%0d", c), (c <= 4) ? 32'h40 : 32'h44);
    end
    next_cycle();
    drive(1'b1, 32'h40, 1'b0);
    check_hit("w9", 32'hAAAA_0001);

    // Evict 0x40 again, then change the request during its fill
    drive(1'b1, 32'hC0, 1'b0);
    repeat (3) next_cycle();
    check_hit("e3", 32'hC000_00C0);
    drive(1'b1, 32'h40, 1'b0);
    check("d0_miss", {31'd0, ihit}, 32'd0);
    next_cycle();
    drive(1'b0, 32'h100, 1'b0);
    check_fill("d1", 32'h40);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0);
    check_fill("d2", 32'h44);
    next_cycle();
    check("d3_miss", {31'd0, ihit}, 32'd0);
    check("d3_iren", {31'd0, iREN}, 32'd0);
    next_cycle();
    check_fill("d4", 32'h100);
    next_cycle();
    check_fill("d5", 32'h104);
    next_cycle();
    check_hit("d6", 32'hC000_0100);
    drive(1'b1, 32'h40, 1'b0);
    check_hit("d7a", 32'hAAAA_0001);
    drive(1'b1, 32'h44, 1'b0);
    check_hit("d7b", 32'hAAAA_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
